// File: rtl/spi_pkg.sv
// Shared encodings for the SPI SCLK engine: FSM state codes and SCLK edge kinds.
package spi_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  // Kind of the next SCLK edge within a bit: leading leaves idle level, trailing returns to it.
  localparam logic LEAD  = 1'b0;
  localparam logic TRAIL = 1'b1;

endpackage

// File: rtl/spi_half_period_timer.sv
// Loadable down-counter producing a one-cycle tick when it reaches its last count.
// Used for SCLK half periods and for chip-select setup/hold delays.
module spi_half_period_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] value,
  output logic             tick
);

  logic [WIDTH-1:0] count_reg;

  // Tick fires in the final cycle of the loaded interval so the caller can register its action on time.
  assign tick = enable && (count_reg == WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= value;
    end else if (enable && (count_reg != '0)) begin
      count_reg <= count_reg - WIDTH'(1);
    end
  end

endmodule

// File: rtl/spi_sclk_engine.sv
// Runtime-programmable SPI master SCLK/timing engine with handshake, abort, strobes and chip select.
// Define SPI_CS_TIMING_EN to add programmable CS setup/hold phases (csSetupIn/csHoldIn).
module spi_sclk_engine
  import spi_pkg::*;
#(
  parameter int DIV_WIDTH = 16,
  parameter int CNT_WIDTH = 6
`ifdef SPI_CS_TIMING_EN
  , parameter int CS_DLY_WIDTH = 4
`endif
) (
  input  logic                 clkIn,
  input  logic                 rstIn,
  input  logic                 startIn,
  input  logic                 abortIn,
  input  logic [DIV_WIDTH-1:0] halfPeriodIn,
  input  logic [CNT_WIDTH-1:0] bitCountIn,
  input  logic                 cpolIn,
  input  logic                 cphaIn,
`ifdef SPI_CS_TIMING_EN
  input  logic [CS_DLY_WIDTH-1:0] csSetupIn,
  input  logic [CS_DLY_WIDTH-1:0] csHoldIn,
`endif
  output logic                 busyOut,
  output logic                 doneOut,
  output logic                 spiClkOut,
  output logic                 sampleStrobeOut,
  output logic                 shiftStrobeOut,
  output logic [CNT_WIDTH-1:0] bitIndexOut,
  output logic                 csNOut
);

  logic [1:0]           state_reg;
  logic [DIV_WIDTH-1:0] h_reg;
  logic [CNT_WIDTH-1:0] n_reg;
  logic                 cpol_reg;
  logic                 cpha_reg;
  logic                 sclk_reg;
  logic                 sample_reg;
  logic                 shift_reg;
  logic                 done_reg;
  logic [CNT_WIDTH-1:0] bit_idx_reg;
  logic                 inc_pending_reg;
  logic                 phase_reg;
  logic                 tail_reg;
`ifdef SPI_CS_TIMING_EN
  logic [CS_DLY_WIDTH-1:0] hold_reg;
`endif

  logic                 tick;
  logic                 tmr_load;
  logic                 tmr_enable;
  logic [DIV_WIDTH-1:0] tmr_value;
  logic [DIV_WIDTH-1:0] half_eff;
  logic                 start_ok;
  logic                 last_bit;

  assign half_eff   = (halfPeriodIn == '0) ? DIV_WIDTH'(1) : halfPeriodIn;
  assign start_ok   = startIn && !abortIn;
  assign last_bit   = (bit_idx_reg == n_reg);
  assign tmr_enable = (state_reg != ST_IDLE);

  always_comb begin
    tmr_load  = 1'b0;
    tmr_value = h_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_ok) begin
          tmr_load  = 1'b1;
          tmr_value = half_eff;
`ifdef SPI_CS_TIMING_EN
          if (csSetupIn != '0) tmr_value = DIV_WIDTH'(csSetupIn);
`endif
        end
      end
      ST_ACTIVE: begin
        if (tick) begin
          tmr_load = 1'b1;
`ifdef SPI_CS_TIMING_EN
          if (tail_reg) tmr_value = DIV_WIDTH'(hold_reg);
`endif
        end
      end
      default: tmr_load = tick;
    endcase
  end

  spi_half_period_timer #(
    .WIDTH (DIV_WIDTH)
  ) u_timer (
    .clk    (clkIn),
    .rst_n  (rstIn),
    .load   (tmr_load),
    .enable (tmr_enable),
    .value  (tmr_value),
    .tick   (tick)
  );

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      state_reg       <= ST_IDLE;
      h_reg           <= '0;
      n_reg           <= '0;
      cpol_reg        <= 1'b0;
      cpha_reg        <= 1'b0;
      sclk_reg        <= 1'b0;
      sample_reg      <= 1'b0;
      shift_reg       <= 1'b0;
      done_reg        <= 1'b0;
      bit_idx_reg     <= '0;
      inc_pending_reg <= 1'b0;
      phase_reg       <= LEAD;
      tail_reg        <= 1'b0;
`ifdef SPI_CS_TIMING_EN
      hold_reg        <= '0;
`endif
    end else begin
      sample_reg <= 1'b0;
      shift_reg  <= 1'b0;
      done_reg   <= 1'b0;
      // The bit index advances one cycle after its trailing edge, so strobes see the current bit.
      if (inc_pending_reg) begin
        bit_idx_reg     <= bit_idx_reg + CNT_WIDTH'(1);
        inc_pending_reg <= 1'b0;
      end

      if ((state_reg != ST_IDLE) && abortIn) begin
        state_reg       <= ST_IDLE;
        sclk_reg        <= cpol_reg;
        bit_idx_reg     <= '0;
        inc_pending_reg <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            sclk_reg <= cpolIn;
            if (start_ok) begin
              h_reg           <= half_eff;
              n_reg           <= bitCountIn;
              cpol_reg        <= cpolIn;
              cpha_reg        <= cphaIn;
              bit_idx_reg     <= '0;
              inc_pending_reg <= 1'b0;
              phase_reg       <= LEAD;
              tail_reg        <= 1'b0;
`ifdef SPI_CS_TIMING_EN
              hold_reg        <= csHoldIn;
              state_reg       <= (csSetupIn != '0) ? ST_SETUP : ST_ACTIVE;
`else
              state_reg       <= ST_ACTIVE;
`endif
            end
          end
          ST_ACTIVE: begin
            if (tick) begin
              if (tail_reg) begin
`ifdef SPI_CS_TIMING_EN
                if (hold_reg != '0) begin
                  state_reg <= ST_HOLD;
                end else begin
                  state_reg <= ST_IDLE;
                  done_reg  <= 1'b1;
                end
`else
                state_reg <= ST_IDLE;
                done_reg  <= 1'b1;
`endif
              end else if (phase_reg == LEAD) begin
                sclk_reg  <= ~sclk_reg;
                phase_reg <= TRAIL;
                if (cpha_reg) shift_reg  <= 1'b1;
                else          sample_reg <= 1'b1;
              end else begin
                sclk_reg  <= ~sclk_reg;
                phase_reg <= LEAD;
                if (cpha_reg)       sample_reg <= 1'b1;
                else if (!last_bit) shift_reg  <= 1'b1;
                if (last_bit) tail_reg        <= 1'b1;
                else          inc_pending_reg <= 1'b1;
              end
            end
          end
`ifdef SPI_CS_TIMING_EN
          ST_SETUP: begin
            if (tick) state_reg <= ST_ACTIVE;
          end
          ST_HOLD: begin
            if (tick) begin
              state_reg <= ST_IDLE;
              done_reg  <= 1'b1;
            end
          end
`endif
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign busyOut         = (state_reg != ST_IDLE);
  assign csNOut          = (state_reg == ST_IDLE);
  assign doneOut         = done_reg;
  assign spiClkOut       = sclk_reg;
  assign sampleStrobeOut = sample_reg;
  assign shiftStrobeOut  = shift_reg;
  assign bitIndexOut     = bit_idx_reg;

endmodule

// File: tb/tb_spi_sclk_engine.sv
// Directed self-checking bench for spi_sclk_engine; define SPI_CS_TIMING_EN to also cover CS setup/hold.
module tb_spi_sclk_engine;

  localparam int DIV_W = 16;
  localparam int CNT_W = 6;

  logic             clkIn = 1'b0;
  logic             rstIn = 1'b0;
  logic             startIn = 1'b0;
  logic             abortIn = 1'b0;
  logic [DIV_W-1:0] halfPeriodIn = '0;
  logic [CNT_W-1:0] bitCountIn = '0;
  logic             cpolIn = 1'b0;
  logic             cphaIn = 1'b0;
`ifdef SPI_CS_TIMING_EN
  logic [3:0]       csSetupIn = '0;
  logic [3:0]       csHoldIn = '0;
`endif
  logic             busyOut;
  logic             doneOut;
  logic             spiClkOut;
  logic             sampleStrobeOut;
  logic             shiftStrobeOut;
  logic [CNT_W-1:0] bitIndexOut;
  logic             csNOut;

  int checks = 0;
  int errors = 0;

  spi_sclk_engine #(
    .DIV_WIDTH (DIV_W),
    .CNT_WIDTH (CNT_W)
  ) dut (
    .clkIn           (clkIn),
    .rstIn           (rstIn),
    .startIn         (startIn),
    .abortIn         (abortIn),
    .halfPeriodIn    (halfPeriodIn),
    .bitCountIn      (bitCountIn),
    .cpolIn          (cpolIn),
    .cphaIn          (cphaIn),
`ifdef SPI_CS_TIMING_EN
    .csSetupIn       (csSetupIn),
    .csHoldIn        (csHoldIn),
`endif
    .busyOut         (busyOut),
    .doneOut         (doneOut),
    .spiClkOut       (spiClkOut),
    .sampleStrobeOut (sampleStrobeOut),
    .shiftStrobeOut  (shiftStrobeOut),
    .bitIndexOut     (bitIndexOut),
    .csNOut          (csNOut)
  );

  always #5 clkIn = ~clkIn;

  task automatic check_value(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Runs one transfer and checks its timing profile; poke_at>0 re-pulses start with new config mid-transfer.
  task automatic run_xfer(input string tag, input int h, input int bc, input bit cpol, input bit cpha,
                          input int poke_at, input int exp_busy, input int exp_edges,
                          input int exp_sample_rise, input int exp_shift_fall, input int exp_first);
    int busy_n = 0, edges = 0, samples = 0, shifts = 0, s_rise = 0, sh_fall = 0;
    int dones = 0, overlap = 0, csn_low = 0, bad_step = 0, bad_gap = 0;
    int first_edge = -1, last_edge = 0, max_idx = 0, h_eff;
    logic prev_clk;
    logic [CNT_W-1:0] prev_idx;
    bit fin = 0;
    h_eff = (h == 0) ? 1 : h;
    halfPeriodIn = DIV_W'(h);
    bitCountIn   = CNT_W'(bc);
    cpolIn       = cpol;
    cphaIn       = cpha;
    @(posedge clkIn); #1;
    @(posedge clkIn); #1;
    check_value({tag, " idle_sclk"}, int'(spiClkOut), int'(cpol));
    startIn = 1'b1;
    @(posedge clkIn); #1;
    startIn  = 1'b0;
    prev_clk = cpol;
    prev_idx = '0;
    for (int c = 0; c < 4000 && !fin; c++) begin
      if (busyOut) busy_n++;
      if (!csNOut) csn_low++;
      if (doneOut) begin
        dones++;
        if (busyOut) overlap++;
      end
      if (spiClkOut !== prev_clk) begin
        edges++;
        if (first_edge < 0) first_edge = busy_n;
        else if (busy_n - last_edge != h_eff) bad_gap++;
        last_edge = busy_n;
      end
      if (sampleStrobeOut) begin
        samples++;
        if (spiClkOut !== prev_clk && spiClkOut) s_rise++;
      end
      if (shiftStrobeOut) begin
        shifts++;
        if (spiClkOut !== prev_clk && !spiClkOut) sh_fall++;
      end
      if (bitIndexOut != prev_idx && int'(bitIndexOut) != int'(prev_idx) + 1) bad_step++;
      if (int'(bitIndexOut) > max_idx) max_idx = int'(bitIndexOut);
      prev_clk = spiClkOut;
      prev_idx = bitIndexOut;
      if (busy_n == poke_at) begin
        startIn      = 1'b1;
        halfPeriodIn = DIV_W'(7);
        bitCountIn   = CNT_W'(1);
        cphaIn       = ~cpha;
      end else begin
        startIn = 1'b0;
      end
      if (busy_n > 0 && !busyOut) fin = 1;
      else begin
        @(posedge clkIn); #1;
      end
    end
    startIn = 1'b0;
    cphaIn  = cpha;
    check_value({tag, " finished"}, int'(fin), 1);
    check_value({tag, " busy_cycles"}, busy_n, exp_busy);
    check_value({tag, " csn_low_cycles"}, csn_low, exp_busy);
    check_value({tag, " edges"}, edges, exp_edges);
    check_value({tag, " first_edge"}, first_edge, exp_first);
    check_value({tag, " edge_gaps_bad"}, bad_gap, 0);
    check_value({tag, " samples"}, samples, exp_sample_rise);
    check_value({tag, " sample_on_rise"}, s_rise, exp_sample_rise);
    check_value({tag, " shifts"}, shifts, exp_shift_fall);
    check_value({tag, " shift_on_fall"}, sh_fall, exp_shift_fall);
    check_value({tag, " done_pulses"}, dones, 1);
    check_value({tag, " done_with_busy"}, overlap, 0);
    check_value({tag, " bit_index_max"}, max_idx, bc);
    check_value({tag, " bit_index_steps_bad"}, bad_step, 0);
    check_value({tag, " sclk_end"}, int'(spiClkOut), int'(cpol));
    $display("xfer %s: busy=%0d edges=%0d samples=%0d shifts=%0d done=%0d max_idx=%0d",
             tag, busy_n, edges, samples, shifts, dones, max_idx);
  endtask

  initial begin
    int n;
    int k;
    int noise;

    // Reset state
    repeat (3) @(posedge clkIn);
    #1;
    check_value("rst busy", int'(busyOut), 0);
    check_value("rst done", int'(doneOut), 0);
    check_value("rst csn", int'(csNOut), 1);
    check_value("rst sclk", int'(spiClkOut), 0);
    check_value("rst strobes", int'(sampleStrobeOut) + int'(shiftStrobeOut), 0);
    check_value("rst bit_index", int'(bitIndexOut), 0);
    $display("reset: busy=%0d csn=%0d sclk=%0d", busyOut, csNOut, spiClkOut);
    rstIn = 1'b1;

    // Main function: (2N+1)*H busy cycles, first edge H cycles after entry
    run_xfer("h2n8_m0", 2, 7, 1'b0, 1'b0, -1, 34, 16, 8, 7, 3);
    run_xfer("h3n4_m3", 3, 3, 1'b1, 1'b1, -1, 27, 8, 4, 4, 4);
    run_xfer("h0n1",    0, 0, 1'b0, 1'b0, -1, 3, 2, 1, 0, 2);

    // Abort mid-transfer at two points, the second while SCLK is away from idle
    for (int a = 0; a < 2; a++) begin
      k = (a == 0) ? 10 : 7;
      halfPeriodIn = DIV_W'(2);
      bitCountIn   = CNT_W'(7);
      cpolIn       = 1'b1;
      cphaIn       = 1'b0;
      @(posedge clkIn); #1;
      @(posedge clkIn); #1;
      startIn = 1'b1;
      @(posedge clkIn); #1;
      startIn = 1'b0;
      n = 1;
      while (n < k) begin
        @(posedge clkIn); #1;
        n++;
      end
      abortIn = 1'b1;
      @(posedge clkIn); #1;
      abortIn = 1'b0;
      check_value("abort busy", int'(busyOut), 0);
      check_value("abort csn", int'(csNOut), 1);
      check_value("abort sclk", int'(spiClkOut), 1);
      check_value("abort bit_index", int'(bitIndexOut), 0);
      check_value("abort done", int'(doneOut), 0);
      noise = 0;
      repeat (6) begin
        @(posedge clkIn); #1;
        noise += int'(doneOut) + int'(sampleStrobeOut) + int'(shiftStrobeOut) + int'(busyOut);
      end
      check_value("abort quiet", noise, 0);
      $display("abort at busy cycle %0d: busy=%0d csn=%0d sclk=%0d", k, busyOut, csNOut, spiClkOut);
    end

    // New transfer after abort, with start and config changes poked mid-transfer
    run_xfer("after_abort_poke", 2, 7, 1'b0, 1'b0, 5, 34, 16, 8, 7, 3);

    // Start and abort in the same idle cycle: nothing starts
    startIn = 1'b1;
    abortIn = 1'b1;
    @(posedge clkIn); #1;
    startIn = 1'b0;
    abortIn = 1'b0;
    check_value("start_abort busy", int'(busyOut), 0);
    check_value("start_abort csn", int'(csNOut), 1);
    @(posedge clkIn); #1;
    check_value("start_abort busy2", int'(busyOut), 0);
    $display("start+abort: busy=%0d csn=%0d", busyOut, csNOut);

    // Asynchronous reset mid-transfer, asserted between clock edges
    halfPeriodIn = DIV_W'(2);
    bitCountIn   = CNT_W'(7);
    cpolIn       = 1'b0;
    cphaIn       = 1'b0;
    @(posedge clkIn); #1;
    startIn = 1'b1;
    @(posedge clkIn); #1;
    startIn = 1'b0;
    n = 1;
    while (n < 12) begin
      @(posedge clkIn); #1;
      n++;
    end
    check_value("pre_rst sclk", int'(spiClkOut), 1);
    check_value("pre_rst bit_index", int'(bitIndexOut), 2);
    #2;
    rstIn = 1'b0;
    #1;
    check_value("async_rst busy", int'(busyOut), 0);
    check_value("async_rst csn", int'(csNOut), 1);
    check_value("async_rst sclk", int'(spiClkOut), 0);
    check_value("async_rst bit_index", int'(bitIndexOut), 0);
    check_value("async_rst pulses", int'(doneOut) + int'(sampleStrobeOut) + int'(shiftStrobeOut), 0);
    $display("async reset: busy=%0d csn=%0d sclk=%0d idx=%0d", busyOut, csNOut, spiClkOut, bitIndexOut);
    @(posedge clkIn); #1;
    rstIn = 1'b1;

`ifdef SPI_CS_TIMING_EN
    // CS setup 3 + (2*2+1)*1 active + hold 2 = 10 busy cycles, first edge after setup + H
    csSetupIn = 4'd3;
    csHoldIn  = 4'd2;
    run_xfer("cs_s3_h2", 1, 1, 1'b0, 1'b0, -1, 10, 4, 2, 1, 5);
    csSetupIn = 4'd0;
    csHoldIn  = 4'd0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_sclk_engine.md
Name: spi_sclk_engine

Overview:
- Runtime-programmable SPI master clock/timing engine for framed transfers.
- Successor to the fixed-parameter SPI clock generator: divider, CPOL, CPHA and bit count are per-transfer inputs; it adds start/busy/done handshake, abort, sample/shift strobes, bit index and chip-select.
- Sits between a register/control block and the SPI shift-register datapath, which consumes the strobes.

Parameters:
- DIV_WIDTH, 16, width of halfPeriodIn (system clocks per SCLK half period).
- CNT_WIDTH, 6, width of bitCountIn and bitIndexOut; max transfer 2^CNT_WIDTH bits.
- CS_DLY_WIDTH, 4, width of CS setup/hold inputs (optional feature only).

Ports:
- clkIn  input  1  system clock, all logic on rising edge.
- rstIn  input  1  reset, asynchronous, active-low.
- startIn  input  1  start request, sampled in IDLE only.
- abortIn  input  1  terminate the transfer in progress.
- halfPeriodIn  input  DIV_WIDTH  SCLK half period H in clkIn cycles; 0 treated as 1.
- bitCountIn  input  CNT_WIDTH  transfer length N = bitCountIn+1 bits.
- cpolIn  input  1  idle SCLK level.
- cphaIn  input  1  0: sample leading/shift trailing; 1: shift leading/sample trailing.
- busyOut  output  1  high from cycle after accepted start until return to IDLE.
- doneOut  output  1  one-cycle pulse on normal completion.
- spiClkOut  output  1  registered SCLK.
- sampleStrobeOut  output  1  one-cycle pulse coincident with a sample edge.
- shiftStrobeOut  output  1  one-cycle pulse coincident with a shift edge.
- bitIndexOut  output  CNT_WIDTH  index of the bit in progress, 0..N-1.
- csNOut  output  1  active-low chip select.

Behaviour:
- Reset (rstIn=0, async): state IDLE; busyOut=0, doneOut=0, strobes=0, bitIndexOut=0, csNOut=1, spiClkOut=0; latched config=0.
- IDLE: spiClkOut tracks cpolIn with one-cycle register lag. startIn=1 and abortIn=0 latches H, N, cpol, cpha; next cycle busyOut=1, csNOut=0, state ACTIVE (SETUP if feature enabled).
- ACTIVE: half-period timer reloads with H on entry and on each tick. Edges occur at H, 2H, …, 2N·H cycles after entry; odd edges are leading, even edges trailing. The spiClkOut toggle and its strobe are registered in the same cycle.
- CPHA=0: sampleStrobe on every leading edge; shiftStrobe on every trailing edge except the last bit's.
- CPHA=1: shiftStrobe on every leading edge; sampleStrobe on every trailing edge.
- bitIndexOut increments in the cycle after each trailing edge, except the last one.
- After edge 2N, wait one further H. Then doneOut=1, busyOut=0, csNOut=1, and the state returns to IDLE (via HOLD if feature enabled). spiClkOut is at cpol.
- Busy length without feature = (2N+1)·H cycles.
- startIn while busy: ignored, no queuing. Config input changes while busy: ignored.
- abortIn in any non-IDLE state: next cycle IDLE, spiClkOut=cpol, csNOut=1, bitIndexOut=0, no doneOut, no further strobes, HOLD skipped.
- abortIn and startIn in the same IDLE cycle: abort wins, start dropped.
- doneOut is never asserted together with busyOut.
- Maximum case (N=2^CNT_WIDTH, H=2^DIV_WIDTH-1): counters must not overflow.

Optional Feature:
- Macro SPI_CS_TIMING_EN.
- Defined: adds inputs csSetupIn and csHoldIn [CS_DLY_WIDTH], latched at start. A SETUP state holds csNOut=0, SCLK idle for csSetupIn cycles before ACTIVE. A HOLD state holds csNOut=0 for csHoldIn cycles after the final half period, then doneOut. A value of 0 skips the state.
- Undefined: these ports and states are absent; csNOut=0 exactly during ACTIVE.

Decomposition:
- Package spi_pkg: state encodings (IDLE, SETUP, ACTIVE, HOLD) and edge-type constants (LEAD, TRAIL).
- One sub-module, spi_half_period_timer: loadable down-counter of DIV_WIDTH bits, with load, enable and one-cycle tick outputs. It is reused for the CS setup/hold delay.

Test Plan:
- H=2, N=8, CPOL=0, CPHA=0, start pulse -> busy 34 cycles, 16 SCLK edges every 2 cycles, 8 sampleStrobes on rising edges, 7 shiftStrobes, one doneOut, bitIndexOut 0..7.
- H=3, N=4, CPOL=1, CPHA=1 -> idle SCLK high; 4 shiftStrobes on falling edges, 4 sampleStrobes on rising edges; busy 27 cycles.
- halfPeriodIn=0, N=1 -> behaves as H=1: busy 3 cycles, 2 edges, doneOut pulse.
- Abort at cycle 10 of an H=2, N=8 transfer -> next cycle busy=0, csNOut=1, SCLK=CPOL, no doneOut; a new start then completes normally. Also cover startIn and abortIn asserted in the same IDLE cycle -> no transfer starts.
- startIn re-pulsed mid-transfer and rstIn asserted mid-transfer -> the start is ignored; reset immediately forces all outputs to their reset values without waiting for a clkIn edge.
- SPI_CS_TIMING_EN defined, csSetup=3, csHold=2, H=1, N=2 -> csNOut low 3 cycles before the first edge and 2 cycles after the final half period; busy 10 cycles.
